// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, vector address
// and cause-width helper.
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_e;

    localparam logic [31:0] IRQ_VECTOR = 32'h0000_0004;

    function automatic int cause_w(input int n_irq);
        return (n_irq < 2) ? 1 : $clog2(n_irq);
    endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// CPU-facing bundle of the interrupt controller; the controller is the slave,
// the CPU/peripheral side is the master.
interface int_ctrl_if #(
    parameter int N_IRQ = 4
);
    import int_ctrl_pkg::*;

    localparam int CW = cause_w(N_IRQ);

    logic [N_IRQ-1:0] irq_in;
    logic [N_IRQ-1:0] irq_mask;
    logic             int_ack;
    logic             eret;
    logic             int_out;
    logic [CW-1:0]    cause;
    logic [N_IRQ-1:0] pending;
    logic             busy;

    modport slave (
        input  irq_in, irq_mask, int_ack, eret,
        output int_out, cause, pending, busy
    );

    modport master (
        output irq_in, irq_mask, int_ack, eret,
        input  int_out, cause, pending, busy
    );

endinterface

// File: rtl/irq_edge_det.sv
// One IRQ line: 2-flop synchroniser, optional debounce filter, rising-edge pulse.
// Debounce is built only when IRQ_DEBOUNCE_EN is defined.
module irq_edge_det #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_i,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
            prev_q  <= level;
        end
    end

`ifdef IRQ_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive cycles where the synchronised level disagrees with the
    // filtered one; any agreement (a bounce back) restarts the window.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    assign edge_o = level & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: per-line edge capture into pending, masked fixed priority
// (index 0 highest), one in-flight request handshaked by int_ack then eret.
// Optional input debounce is enabled with IRQ_DEBOUNCE_EN.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int N_IRQ     = 4,
    parameter int DB_CYCLES = 16
) (
    input logic       clk,
    input logic       reset,
    int_ctrl_if.slave bus
);

    localparam int CW = cause_w(N_IRQ);

    state_e           state_q, state_d;
    logic [CW-1:0]    cause_q, cause_d;
    logic             int_out_q, int_out_d;
    logic [N_IRQ-1:0] pending_q, pending_d;

    logic [N_IRQ-1:0] edge_vec;
    logic [N_IRQ-1:0] req_vec;
    logic [N_IRQ-1:0] clr_vec;
    logic [CW-1:0]    winner;

    generate
        for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_line
            irq_edge_det #(
                .DB_CYCLES (DB_CYCLES)
            ) u_edge (
                .clk    (clk),
                .reset  (reset),
                .irq_i  (bus.irq_in[gi]),
                .edge_o (edge_vec[gi])
            );
        end
    endgenerate

    assign req_vec = pending_q & bus.irq_mask;

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        winner = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                winner = CW'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        int_out_d = int_out_q;
        clr_vec   = '0;
        case (state_q)
            S_IDLE: begin
                if (req_vec != '0) begin
                    state_d   = S_REQ;
                    cause_d   = winner;
                    int_out_d = 1'b1;
                end
            end
            S_REQ: begin
                if (bus.int_ack) begin
                    state_d          = S_SERVICE;
                    int_out_d        = 1'b0;
                    clr_vec[cause_q] = 1'b1;
                end
            end
            S_SERVICE: begin
                int_out_d = 1'b0;
                if (bus.eret) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                int_out_d = 1'b0;
            end
        endcase
        // A new edge in the ack cycle keeps its bit set.
        pending_d = (pending_q & ~clr_vec) | edge_vec;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cause_q   <= '0;
            int_out_q <= 1'b0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            int_out_q <= int_out_d;
            pending_q <= pending_d;
        end
    end

    assign bus.int_out = int_out_q;
    assign bus.cause   = cause_q;
    assign bus.pending = pending_q;
    assign bus.busy    = (state_q != S_IDLE);

endmodule
